// File: rtl/conv3x3_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared geometry, state encoding and index helpers for the
//                time-shared 3x3 convolution sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

  localparam int IMG = 5;              // tile edge in pixels
  localparam int K   = 3;              // kernel edge / datapath taps
  localparam int DW  = 8;              // pixel and weight width (signed)
  localparam int AW  = 20;             // accumulator and result width
  localparam int OUT = IMG - K + 1;    // output edge (valid convolution)

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bit offset of pixel (r,c) inside the flattened tile
  function automatic int pix_lsb(input int r, input int c);
    return DW * (r * IMG + c);
  endfunction

  // Bit offset of weight (kr,kc) inside the flattened kernel
  function automatic int wgt_lsb(input int kr, input int kc);
    return DW * (kr * K + kc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_sched_mac3_tap.sv
`default_nettype none
// ============================================================================
//  Module      : mac3_tap
//  Description : Combinational K-tap signed multiply-add. Each tap is a
//                signed DW x DW product, sign-extended to AW and summed.
//  Revision    : 1.0  initial release
// ============================================================================
module mac3_tap
  import conv_pkg::*;
(
  input  logic [K*DW-1:0] pix,
  input  logic [K*DW-1:0] wgt,
  output logic [AW-1:0]   sum
);

  logic signed [2*DW-1:0] prod [K];
  logic signed [AW-1:0]   acc;

  // One signed product per tap; full-width so no precision is lost
  for (genvar i = 0; i < K; i++) begin : g_tap
    assign prod[i] = $signed(pix[i*DW +: DW]) * $signed(wgt[i*DW +: DW]);
  end

  // Sign-extend each product and add the taps together
  always_comb begin
    acc = '0;
    for (int i = 0; i < K; i++) begin
      acc = acc + AW'(prod[i]);
    end
  end

  assign sum = acc;

endmodule
`default_nettype wire

// File: rtl/conv3x3_sched.sv
`default_nettype none
// ============================================================================
//  Module      : conv3x3_sched
//  Description : Valid 3x3 convolution of a 5x5 signed tile using a single
//                shared 3-tap multiply-add. One kernel row per enabled cycle,
//                three cycles per output, nine results over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module conv3x3_sched
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IMG*IMG*DW-1:0] f,
  input  logic [K*K*DW-1:0]     w,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AW-1:0]         out_data,
  output logic [1:0]            out_row,
  output logic [1:0]            out_col,
  output logic                  done
);

  logic [1:0]            state_q, state_d;
  logic [IMG*IMG*DW-1:0] f_q, f_d;
  logic [K*K*DW-1:0]     w_q, w_d;
  logic [1:0]            orow_q, orow_d;
  logic [1:0]            ocol_q, ocol_d;
  logic [1:0]            kr_q, kr_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  out_valid_q, out_valid_d;
  logic [AW-1:0]         out_data_q, out_data_d;
  logic [1:0]            out_row_q, out_row_d;
  logic [1:0]            out_col_q, out_col_d;

  logic [K*DW-1:0]       pix_row;
  logic [K*DW-1:0]       wgt_row;
  logic signed [AW-1:0]  tap;
  logic signed [AW-1:0]  acc_base;
  logic                  handshake;
  logic                  step;
  logic                  row_end;
  logic                  tile_end;

  // A pending result that is not being taken freezes the whole datapath
  assign handshake = out_valid_q & out_ready;
  assign step      = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign row_end   = (kr_q == 2'(K - 1));
  assign tile_end  = (orow_q == 2'(OUT - 1)) && (ocol_q == 2'(OUT - 1));

  // Select the kernel row and the matching pixel row for this step
  always_comb begin
    pix_row = '0;
    wgt_row = '0;
    for (int kc = 0; kc < K; kc++) begin
      pix_row[kc*DW +: DW] = f_q[pix_lsb(int'(orow_q) + int'(kr_q), int'(ocol_q) + kc) +: DW];
      wgt_row[kc*DW +: DW] = w_q[wgt_lsb(int'(kr_q), kc) +: DW];
    end
  end

  mac3_tap u_mac3_tap (
    .pix (pix_row),
    .wgt (wgt_row),
    .sum (tap)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; DRAIN waits for the final result to be taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (step && row_end && tile_end) state_d = ST_DRAIN;
      ST_DRAIN: if (handshake) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  // Datapath next-state: operand capture, raster counters, accumulation
  always_comb begin
    f_d         = f_q;
    w_d         = w_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    kr_d        = kr_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    acc_base    = (kr_q == 2'd0) ? '0 : acc_q;

    if ((state_q == ST_IDLE) && start) begin
      f_d    = f;
      w_d    = w;
      orow_d = 2'd0;
      ocol_d = 2'd0;
      kr_d   = 2'd0;
      acc_d  = '0;
    end

    if (handshake) begin
      out_valid_d = 1'b0;
    end

    // A result loading on the same edge as a handshake keeps valid high
    if (step) begin
      acc_d = acc_base + tap;
      if (row_end) begin
        kr_d        = 2'd0;
        out_data_d  = acc_base + tap;
        out_row_d   = orow_q;
        out_col_d   = ocol_q;
        out_valid_d = 1'b1;
        if (ocol_q == 2'(OUT - 1)) begin
          ocol_d = 2'd0;
          orow_d = tile_end ? 2'd0 : orow_q + 2'd1;
        end else begin
          ocol_d = ocol_q + 2'd1;
        end
      end else begin
        kr_d = kr_q + 2'd1;
      end
    end
  end

  // Datapath registers; reset abandons any tile in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q         <= '0;
      w_q         <= '0;
      orow_q      <= 2'd0;
      ocol_q      <= 2'd0;
      kr_q        <= 2'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= 2'd0;
      out_col_q   <= 2'd0;
    end else begin
      f_q         <= f_d;
      w_q         <= w_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      kr_q        <= kr_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv3x3_sched
//  Description : Self-checking bench for conv3x3_sched. Expected results come
//                from a direct arithmetic convolution of the tile.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv3x3_sched;

  localparam int N  = 5;
  localparam int KK = 3;
  localparam int PW = 8;
  localparam int OW = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              out_ready;
  logic [N*N*PW-1:0] f;
  logic [KK*KK*PW-1:0] w;
  logic              busy;
  logic              out_valid;
  logic [OW-1:0]     out_data;
  logic [1:0]        out_row;
  logic [1:0]        out_col;
  logic              done;

  logic [N*N*PW-1:0]   f_t;
  logic [KK*KK*PW-1:0] w_t;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  conv3x3_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .f         (f),
    .w         (w),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: output o of the valid convolution, raster order
  function automatic int ref_conv(input int o);
    int r0, c0, s, px, wt;
    r0 = o / 3;
    c0 = o % 3;
    s  = 0;
    for (int i = 0; i < KK; i++) begin
      for (int j = 0; j < KK; j++) begin
        px = $signed(f_t[PW*((r0+i)*N + (c0+j)) +: PW]);
        wt = $signed(w_t[PW*(i*KK + j) +: PW]);
        s  = s + px * wt;
      end
    end
    return s;
  endfunction

  task automatic rand_tile();
    for (int i = 0; i < N*N; i++) f_t[i*PW +: PW] = PW'($urandom);
    for (int i = 0; i < KK*KK; i++) w_t[i*PW +: PW] = PW'($urandom);
  endtask

  // mode 0: ready always high, cycle-exact timing checks
  // mode 1: random ready with a 10-cycle low hold
  // mode 2: ready high, second start pulse with new operands mid-tile
  // mode 3: random ready, reset while the 4th result is pending
  task automatic run_tile(input int mode);
    int exp_v[9];
    int got_n, cyc, hold;
    bit pend, saw_done, first_seen, hold_used, restarted, rdy;
    logic [OW-1:0] h_data;
    logic [1:0]    h_row, h_col;

    for (int o = 0; o < 9; o++) exp_v[o] = ref_conv(o);
    got_n = 0; cyc = 0; hold = 0;
    pend = 0; saw_done = 0; first_seen = 0; hold_used = 0; restarted = 0;
    h_data = '0; h_row = '0; h_col = '0;

    f = f_t; w = w_t; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;

    while (cyc < 400 && !saw_done) begin
      if (done) begin
        saw_done = 1;
        check_eq("done_result_count", got_n, 9);
        if (mode == 0) check_eq("done_cycle", cyc, 29);
      end else begin
        check_eq("busy_in_tile", busy, 1);
        if (pend) begin
          check_eq("stall_valid", out_valid, 1);
          check_eq("stall_data", $signed(out_data), $signed(h_data));
          check_eq("stall_row", out_row, h_row);
          check_eq("stall_col", out_col, h_col);
        end
        if (out_valid && !first_seen) begin
          first_seen = 1;
          if (mode == 0) check_eq("first_valid_cycle", cyc, 4);
        end

        if (mode == 3 && got_n == 3 && out_valid) begin
          rst = 1'b1; out_ready = 1'b0;
          @(negedge clk);
          check_eq("abort_busy", busy, 0);
          check_eq("abort_valid", out_valid, 0);
          check_eq("abort_data", out_data, 0);
          check_eq("abort_row", out_row, 0);
          check_eq("abort_col", out_col, 0);
          check_eq("abort_done", done, 0);
          rst = 1'b0;
          return;
        end

        if (mode == 2 && got_n == 2 && out_valid && !restarted) begin
          restarted = 1;
          start = 1'b1;
          f = ~f_t;
          w = {KK*KK{8'h7f}};
        end

        if (mode == 1 || mode == 3) begin
          if (mode == 1 && got_n == 4 && !hold_used) begin
            hold_used = 1;
            hold = 10;
          end
          if (hold > 0) begin
            rdy = 0;
            hold--;
          end else begin
            rdy = $urandom_range(0, 1) == 1;
          end
        end else begin
          rdy = 1;
        end
        out_ready = rdy;

        if (out_valid && rdy) begin
          if (got_n < 9) begin
            check_eq("result_data", $signed(out_data), exp_v[got_n]);
            check_eq("result_row", out_row, got_n / 3);
            check_eq("result_col", out_col, got_n % 3);
          end else begin
            check_eq("extra_result", got_n, 8);
          end
          got_n++;
          pend = 0;
        end else if (out_valid) begin
          pend = 1;
          h_data = out_data; h_row = out_row; h_col = out_col;
        end else begin
          pend = 0;
        end
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end

    if (!saw_done) begin
      check_eq("tile_timeout", 0, 1);
    end else begin
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_after_done", busy, 0);
      check_eq("valid_after_done", out_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; f = '0; w = '0;
    f_t = '0; w_t = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_valid", out_valid, 0);
    check_eq("reset_data", out_data, 0);
    check_eq("reset_row", out_row, 0);
    check_eq("reset_col", out_col, 0);
    check_eq("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // All ones: every result is 9
    f_t = {N*N{8'sd1}}; w_t = {KK*KK{8'sd1}};
    run_tile(0);

    // Ramp image, centre-only kernel: picks pix(r+1,c+1)
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        f_t[PW*(r*N + c) +: PW] = PW'(5*r + c);
    w_t = '0;
    w_t[PW*4 +: PW] = 8'sd1;
    run_tile(0);

    // Extremes
    f_t = {N*N{8'h80}}; w_t = {KK*KK{8'h80}};
    run_tile(0);
    w_t = {KK*KK{8'h7f}};
    run_tile(0);

    // Back-pressure with a long hold
    rand_tile();
    run_tile(1);
    rand_tile();
    run_tile(1);

    // Restart request while busy is ignored
    rand_tile();
    run_tile(2);

    // Reset abort, then a fresh complete tile
    rand_tile();
    run_tile(3);
    @(negedge clk);
    rand_tile();
    run_tile(0);
    rand_tile();
    run_tile(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
